// File: rtl/rv32_muldiv_seq_if.sv
// Core-side handshake bundle for the sequential RV32M multiply/divide unit.
interface rv32_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            m_valid;
    logic [2:0]      m_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            kill;
    logic            m_ready;
    logic            m_busy;
    logic            m_done;
    logic [XLEN-1:0] m_result;

    modport master (output m_valid, m_op, operand_a, operand_b, kill,
                    input  m_ready, m_busy, m_done, m_result);
    modport slave  (input  m_valid, m_op, operand_a, operand_b, kill,
                    output m_ready, m_busy, m_done, m_result);
endinterface

// File: rtl/rv32_muldiv_seq.sv
// Multi-cycle RV32M unit: shift-add multiply, restoring divide on magnitudes,
// sign correction in FIN, and a two-cycle fast path for divide special cases.
module rv32_muldiv_seq #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    rv32_muldiv_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;       // product, remainder, or fast-path result
    logic [PW-1:0]     mcand_q, mcand_d;   // shifted multiplicand, or divisor in low half
    logic [XLEN-1:0]   shreg_q, shreg_d;   // multiplier bits, or dividend becoming quotient
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Accept-time operand decode: effective signs, magnitudes, special cases
    logic            is_div, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    always_comb begin
        is_div   = bus.m_op[2];
        sa       = bus.operand_a[XLEN-1] &
                   ((bus.m_op == 3'b001) | (bus.m_op == 3'b010) | (is_div & ~bus.m_op[0]));
        sb       = bus.operand_b[XLEN-1] & ((bus.m_op == 3'b001) | (is_div & ~bus.m_op[0]));
        a_mag    = sa ? -bus.operand_a : bus.operand_a;
        b_mag    = sb ? -bus.operand_b : bus.operand_b;
        div_zero = is_div & (bus.operand_b == '0);
        div_ovf  = is_div & ~bus.m_op[0] & (&bus.operand_b) &
                   (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}});
        if (div_zero) spec_res = bus.m_op[1] ? bus.operand_a : '1;
        else          spec_res = bus.m_op[1] ? '0 : bus.operand_a;
    end

    // One iteration of the datapath for each algorithm
    logic [PW-1:0] pp_sum;
    logic [XLEN:0] rem_sh;
    logic          q_bit;
    always_comb begin
        pp_sum = acc_q;
        for (int j = 0; j < int'(MUL_UNROLL); j++) begin
            if (shreg_q[j]) pp_sum = pp_sum + (mcand_q << j);
        end
        rem_sh = {acc_q[XLEN-1:0], shreg_q[XLEN-1]};
        q_bit  = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
        if (q_bit) rem_sh = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
    end

    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fin_res;
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -shreg_q : shreg_q;
        rem_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (special_q)      fin_res = acc_q[XLEN-1:0];
        else if (op_q[2])   fin_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == 3'b000) fin_res = prod_fix[XLEN-1:0];
        else                fin_res = prod_fix[PW-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ready_q && bus.m_valid && !bus.kill) begin
                    op_d      = bus.m_op;
                    neg_d     = (bus.m_op[2] & bus.m_op[1]) ? sa : (sa ^ sb);
                    special_d = div_zero | div_ovf;
                    cnt_d     = '0;
                    mcand_d   = {{XLEN{1'b0}}, is_div ? b_mag : a_mag};
                    shreg_d   = is_div ? a_mag : b_mag;
                    acc_d     = (div_zero | div_ovf) ? {{XLEN{1'b0}}, spec_res} : '0;
                    state_d   = (div_zero | div_ovf) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_d   = {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
                        shreg_d = {shreg_q[XLEN-2:0], q_bit};
                    end else begin
                        acc_d   = pp_sum;
                        mcand_d = mcand_q << MUL_UNROLL;
                        shreg_d = shreg_q >> MUL_UNROLL;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == (op_q[2] ? DIV_LAST : MUL_LAST)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!bus.kill) begin
                    result_d = fin_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The cycle carrying m_done is a closed IDLE cycle; requests resume after it
        ready_d = (state_d == S_IDLE) & ~done_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            shreg_q   <= '0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.m_ready  = ready_q;
    assign bus.m_busy   = busy_q;
    assign bus.m_done   = done_q;
    assign bus.m_result = result_q;
endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// Bench for rv32_muldiv_seq: MUL_UNROLL=1 and MUL_UNROLL=4 instances driven in lockstep.
module tb_rv32_muldiv_seq;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_muldiv_seq_if #(.XLEN(XLEN)) ifc1 ();
    rv32_muldiv_seq_if #(.XLEN(XLEN)) ifc4 ();

    rv32_muldiv_seq #(.XLEN(XLEN), .MUL_UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    rv32_muldiv_seq #(.XLEN(XLEN), .MUL_UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

    int vectors     = 0;
    int miscompares = 0;
    int dn1 = 0;
    int dn4 = 0;
    logic [31:0] last_res = '0;

    always @(negedge clk) begin
        if (ifc1.m_done === 1'b1) dn1++;
        if (ifc4.m_done === 1'b1) dn4++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic k);
        ifc1.m_valid = v; ifc1.m_op = op; ifc1.operand_a = a; ifc1.operand_b = b; ifc1.kill = k;
        ifc4.m_valid = v; ifc4.m_op = op; ifc4.operand_a = a; ifc4.operand_b = b; ifc4.kill = k;
    endtask

    task automatic drive_idle_noise();
        drive(1'b0, 3'($urandom), $urandom, $urandom, 1'b0);
    endtask

    // Architectural RV32M result, from plain 64-bit / signed arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        longint x, y;
        logic [63:0] p;
        sa = a; sb = b;
        case (op)
            3'b000: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; return p[31:0];  end
            3'b001: begin x = sa;         y = sb;         p = x * y; return p[63:32]; end
            3'b010: begin x = sa;         y = {32'b0, b}; p = x * y; return p[63:32]; end
            3'b011: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int u);
        if (op[2]) begin
            if (b == 0) return 2;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
        return 32 / u + 2;
    endfunction

    // Issue one op from a negedge with both units idle; returns at the negedge after the last m_done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int pulse_at);
        logic [31:0] exp_r, r1, r4;
        int lat1, lat4;
        logic rd1, rd4;
        exp_r = ref_result(op, a, b);
        chk({tag, "/ready1"}, 32'(ifc1.m_ready), 32'd1);
        chk({tag, "/ready4"}, 32'(ifc4.m_ready), 32'd1);
        drive(1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive_idle_noise();
        lat1 = -1; lat4 = -1; r1 = '0; r4 = '0; rd1 = 1'b1; rd4 = 1'b1;
        for (int cyc = 1; cyc <= 60 && (lat1 < 0 || lat4 < 0); cyc++) begin
            if (ifc1.m_done === 1'b1 && lat1 < 0) begin lat1 = cyc; r1 = ifc1.m_result; rd1 = ifc1.m_ready; end
            if (ifc4.m_done === 1'b1 && lat4 < 0) begin lat4 = cyc; r4 = ifc4.m_result; rd4 = ifc4.m_ready; end
            if (cyc == pulse_at) drive(1'b1, 3'b000, $urandom, $urandom, 1'b0);
            else if (cyc == pulse_at + 1) drive_idle_noise();
            @(negedge clk);
        end
        chk({tag, "/lat1"},   32'(lat1), 32'(ref_lat(op, a, b, 1)));
        chk({tag, "/lat4"},   32'(lat4), 32'(ref_lat(op, a, b, 4)));
        chk({tag, "/res1"},   r1, exp_r);
        chk({tag, "/res4"},   r4, exp_r);
        chk({tag, "/rdy_done1"}, 32'(rd1), 32'd0);
        chk({tag, "/rdy_done4"}, 32'(rd4), 32'd0);
        last_res = exp_r;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] res);
        chk({tag, "/ready1"}, 32'(ifc1.m_ready), 32'd1);
        chk({tag, "/busy1"},  32'(ifc1.m_busy),  32'd0);
        chk({tag, "/done1"},  32'(ifc1.m_done),  32'd0);
        chk({tag, "/res1"},   ifc1.m_result, res);
        chk({tag, "/ready4"}, 32'(ifc4.m_ready), 32'd1);
        chk({tag, "/busy4"},  32'(ifc4.m_busy),  32'd0);
        chk({tag, "/done4"},  32'(ifc4.m_done),  32'd0);
        chk({tag, "/res4"},   ifc4.m_result, res);
    endtask

    initial begin
        int s1, s4;
        logic [2:0] op;
        logic [31:0] a, b;

        rst = 1'b1;
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk_idle("reset", 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min", 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0);
        run_op(3'b101, 32'h1234, 32'h0, "divu_by0", 0);
        run_op(3'b110, 32'h1234, 32'h0, "rem_by0", 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);

        // DIVU killed mid-calculation: no m_done, result held
        drive(1'b1, 3'b101, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        drive_idle_noise();
        s1 = dn1; s4 = dn4;
        repeat (8) @(negedge clk);
        drive(1'b0, 3'b000, '0, '0, 1'b1);
        @(negedge clk);
        drive_idle_noise();
        chk_idle("kill_calc", last_res);
        repeat (40) @(negedge clk);
        chk("kill_calc/nodone1", 32'(dn1 - s1), 32'd0);
        chk("kill_calc/nodone4", 32'(dn4 - s4), 32'd0);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_busy_pulse", 5);
        s1 = dn1; s4 = dn4;
        repeat (40) @(negedge clk);
        chk("busy_pulse/nodone1", 32'(dn1 - s1), 32'd0);
        chk("busy_pulse/nodone4", 32'(dn4 - s4), 32'd0);
        chk_idle("busy_pulse_idle", last_res);

        // Request dropped when kill accompanies m_valid in IDLE
        s1 = dn1; s4 = dn4;
        drive(1'b1, 3'b000, 32'd3, 32'd5, 1'b1);
        @(negedge clk);
        drive_idle_noise();
        chk_idle("kill_idle", last_res);
        repeat (5) @(negedge clk);
        chk("kill_idle/nodone1", 32'(dn1 - s1), 32'd0);
        chk("kill_idle/nodone4", 32'(dn4 - s4), 32'd0);

        // Kill landing on the FIN cycle of a fast-path divide wins over m_done
        s1 = dn1; s4 = dn4;
        drive(1'b1, 3'b101, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'b000, '0, '0, 1'b1);
        @(negedge clk);
        drive_idle_noise();
        chk_idle("kill_fin", last_res);
        repeat (5) @(negedge clk);
        chk("kill_fin/nodone1", 32'(dn1 - s1), 32'd0);
        chk("kill_fin/nodone4", 32'(dn4 - s4), 32'd0);

        run_op(3'b000, 32'd3, 32'd5, "b2b_mul", 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, "b2b_mulhsu", 0);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom); a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            run_op(op, a, b, $sformatf("rand%0d", i), 0);
        end

        // Reset asserted for two cycles in the middle of a DIV
        run_op(3'b000, 32'd7, 32'd9, "pre_reset", 0);
        s1 = dn1; s4 = dn4;
        drive(1'b1, 3'b100, 32'h1234_5678, 32'h0000_0123, 1'b0);
        @(negedge clk);
        drive_idle_noise();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset_mid", 32'h0);
        repeat (40) @(negedge clk);
        chk("reset_mid/nodone1", 32'(dn1 - s1), 32'd0);
        chk("reset_mid/nodone4", 32'(dn4 - s4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv32_muldiv_seq.md
Name: rv32_muldiv_seq

Overview:
- Parametrised, multi-cycle RV32M multiply/divide unit.
- Replaces the combinational M-extension datapath so the core can close timing at higher clock rates. The core stalls its PC while the unit is busy.
- Adds the following over the combinational path: valid/done handshake, kill/abort, configurable multiply throughput, and a fast path for the divide special cases.

Parameters:
- XLEN, 32: operand and result width; must be even and ≥ 8.
- MUL_UNROLL, 1: multiplier bits retired per cycle; allowed values 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  1  start request; sampled only when m_ready=1.
- m_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  XLEN  rs1 value; captured on accept.
- operand_b  in  XLEN  rs2 value; captured on accept.
- kill  in  1  abort the in-flight operation (trap or flush).
- m_ready  out  1  high in IDLE only.
- m_busy  out  1  high while an operation is in flight; the core ORs this into its stall.
- m_done  out  1  single-cycle pulse; m_result is valid in this cycle.
- m_result  out  XLEN  result register; holds its value until the next m_done.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge):
  - State returns to IDLE and the counter clears.
  - m_ready=1, m_busy=0, m_done=0, m_result=0.
  - Reset overrides kill and m_valid, and aborts any in-flight operation.
- FSM states:
  - IDLE: m_ready=1. On m_valid, latch operand_a, operand_b and m_op, then:
    - Special case (below) → FIN.
    - Otherwise → CALC.
  - CALC:
    - Multiply: iteration counter runs XLEN/MUL_UNROLL cycles.
    - Divide: runs XLEN cycles.
    - Counter reaching its terminal value → FIN.
  - FIN: apply sign correction, write m_result, assert m_done. Next state IDLE.
- Latency: m_valid accepted at edge k → m_done high during cycle k+L.
  - Multiply: L = XLEN/MUL_UNROLL + 2.
  - Divide: L = XLEN + 2.
  - Special case: L = 2.
  - A new m_valid is accepted no earlier than the cycle after m_done; the IDLE cycle is required.
- Multiply:
  - Operands are sign-extended to XLEN+1 bits per op: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned×unsigned.
  - Product is 2·XLEN bits, built by shift-add of MUL_UNROLL partial products per cycle.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring algorithm, 1 quotient bit per cycle, on magnitudes.
  - Quotient is negated iff signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Special cases, fast path:
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return operand_a.
  - Signed overflow (operand_a = −2^(XLEN−1), operand_b = −1, DIV/REM): DIV returns operand_a; REM returns 0.
- m_valid while busy: ignored, with no effect on the in-flight operation.
- kill:
  - At any edge with state ≠ IDLE: → IDLE next cycle. No m_done; m_result unchanged.
  - kill in IDLE with m_valid: the request is dropped.
  - kill coincident with FIN: kill wins, so no m_done.
- Operand inputs may change after accept without affecting the result.
- m_result changes only in the cycle m_done is asserted.

Test Plan:
- Reset: assert rst for 2 cycles mid-CALC of a DIV → m_ready=1, m_busy=0, m_done=0, m_result=0; no m_done pulse follows.
- MULH, XLEN=32, MUL_UNROLL=1: a=0x8000_0000, b=0x8000_0000 → m_done exactly 34 cycles after accept, m_result=0x4000_0000. Repeat with MUL_UNROLL=4 → 10 cycles, same result.
- Signed divide: DIV a=−7 (0xFFFF_FFF9), b=2 → 0xFFFF_FFFD (−3), 34 cycles. REM on the same operands → 0xFFFF_FFFF (−1).
- Special cases, each with m_done 2 cycles after accept:
  - DIVU a=0x1234, b=0 → 0xFFFF_FFFF.
  - REM a=0x1234, b=0 → 0x1234.
  - DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000.
  - REM a=0x8000_0000, b=0xFFFF_FFFF → 0.
- Kill and busy: start DIVU 100/7, assert kill at cycle 10 → no m_done, m_result unchanged, m_ready=1 next cycle. Then start MULHU 0xFFFF_FFFF×0xFFFF_FFFF and pulse m_valid with other operands mid-CALC → result 0xFFFF_FFFE, second request ignored.
- Back-to-back: MUL 3×5 then immediate MULHSU −1×2 → m_results 15 then 0xFFFF_FFFF. The second m_valid is accepted only in the cycle after the first m_done.
